// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter (fetch, load/store, debug) onto one memory port with a BUSY timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority dbg > ls > if.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic        ls_req,
  input  logic        dbg_req,
  input  logic [31:0] if_addr,
  input  logic [31:0] ls_addr,
  input  logic [31:0] dbg_addr,
  input  logic [3:0]  if_we,
  input  logic [3:0]  ls_we,
  input  logic [3:0]  dbg_we,
  input  logic [31:0] if_wdata,
  input  logic [31:0] ls_wdata,
  input  logic [31:0] dbg_wdata,
  output logic        if_gnt,
  output logic        ls_gnt,
  output logic        dbg_gnt,
  output logic        if_rvalid,
  output logic        ls_rvalid,
  output logic        dbg_rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state_q;
  logic [7:0]  count_q;
  logic [2:0]  owner_q;
  logic [31:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;
  logic        rstHold_q;

  logic [2:0]  reqVec;
  logic [2:0]  winVec;
  logic [2:0]  gntVec;
  logic [2:0]  rvalidVec;
  logic        grant;
  logic        busy;
  logic        done;
  logic [31:0] selAddr;
  logic [3:0]  selWe;
  logic [31:0] selWdata;

  assign reqVec = {dbg_req, ls_req, if_req};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_q names the requester searched first: 0=if, 1=ls, 2=dbg.
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  always_comb begin
    winVec = 3'b000;
    case (ptr_q)
      2'd1:    winVec = reqVec[1] ? 3'b010 : reqVec[2] ? 3'b100 : reqVec[0] ? 3'b001 : 3'b000;
      2'd2:    winVec = reqVec[2] ? 3'b100 : reqVec[0] ? 3'b001 : reqVec[1] ? 3'b010 : 3'b000;
      default: winVec = reqVec[0] ? 3'b001 : reqVec[1] ? 3'b010 : reqVec[2] ? 3'b100 : 3'b000;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gntVec[0])      ptr_d = 2'd1;
    else if (gntVec[1]) ptr_d = 2'd2;
    else if (gntVec[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    winVec = 3'b000;
    if (dbg_req)     winVec = 3'b100;
    else if (ls_req) winVec = 3'b010;
    else if (if_req) winVec = 3'b001;
  end
`endif

  // No grants while reset is low or in the first cycle after it.
  assign gntVec    = (reset && !rstHold_q && state_q == IDLE) ? winVec : 3'b000;
  assign grant     = |gntVec;
  assign busy      = reset && (state_q == BUSY);
  assign done      = busy && (mem_ready || count_q == LAST_CNT);
  assign rvalidVec = done ? owner_q : 3'b000;

  always_comb begin
    selAddr  = 32'h0;
    selWe    = 4'h0;
    selWdata = 32'h0;
    if (gntVec[2]) begin
      selAddr  = dbg_addr;
      selWe    = dbg_we;
      selWdata = dbg_wdata;
    end else if (gntVec[1]) begin
      selAddr  = ls_addr;
      selWe    = ls_we;
      selWdata = ls_wdata;
    end else if (gntVec[0]) begin
      selAddr  = if_addr;
      selWe    = if_we;
      selWdata = if_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 8'd0;
      owner_q   <= 3'b000;
      addr_q    <= 32'h0;
      we_q      <= 4'h0;
      wdata_q   <= 32'h0;
      rstHold_q <= 1'b1;
    end else begin
      rstHold_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= BUSY;
            count_q <= 8'd0;
            owner_q <= gntVec;
            addr_q  <= selAddr;
            we_q    <= selWe;
            wdata_q <= selWdata;
          end
        end
        BUSY: begin
          if (done) begin
            state_q <= IDLE;
            owner_q <= 3'b000;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {dbg_gnt, ls_gnt, if_gnt}          = gntVec;
  assign {dbg_rvalid, ls_rvalid, if_rvalid} = rvalidVec;
  assign err       = done && !mem_ready;
  assign rdata     = (done && mem_ready) ? mem_rdata : 32'h0;
  assign mem_req   = busy;
  assign mem_addr  = busy ? addr_q  : 32'h0;
  assign mem_we    = busy ? we_q    : 4'h0;
  assign mem_wdata = busy ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants and completions are predicted when stimulus is driven.
// Follows MEM_ARB_ROUND_ROBIN_EN to pick the expected arbitration order.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, dbg_req;
  logic [31:0] if_addr, ls_addr, dbg_addr;
  logic [3:0]  if_we, ls_we, dbg_we;
  logic [31:0] if_wdata, ls_wdata, dbg_wdata;
  logic        if_gnt, ls_gnt, dbg_gnt;
  logic        if_rvalid, ls_rvalid, dbg_rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  who;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } gntExp_t;

  typedef struct packed {
    logic [2:0]  who;
    logic [31:0] rdata;
    logic        err;
  } doneExp_t;

  gntExp_t  gntQ[$];
  doneExp_t doneQ[$];
  gntExp_t  curGnt;

  logic [2:0] gntVec;
  logic [2:0] rvalidVec;
  assign gntVec    = {dbg_gnt, ls_gnt, if_gnt};
  assign rvalidVec = {dbg_rvalid, ls_rvalid, if_rvalid};

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .ls_req(ls_req), .dbg_req(dbg_req),
    .if_addr(if_addr), .ls_addr(ls_addr), .dbg_addr(dbg_addr),
    .if_we(if_we), .ls_we(ls_we), .dbg_we(dbg_we),
    .if_wdata(if_wdata), .ls_wdata(ls_wdata), .dbg_wdata(dbg_wdata),
    .if_gnt(if_gnt), .ls_gnt(ls_gnt), .dbg_gnt(dbg_gnt),
    .if_rvalid(if_rvalid), .ls_rvalid(ls_rvalid), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] who, input logic req, input logic [31:0] addr,
                               input logic [3:0] we, input logic [31:0] wdata);
    if (who[0]) begin if_req = req;  if_addr = addr;  if_we = we;  if_wdata = wdata;  end
    if (who[1]) begin ls_req = req;  ls_addr = addr;  ls_we = we;  ls_wdata = wdata;  end
    if (who[2]) begin dbg_req = req; dbg_addr = addr; dbg_we = we; dbg_wdata = wdata; end
  endtask

  // Scoreboard side: compare grants, the held memory port and completions.
  always @(negedge clk) begin
    checkOutput("gntOneHot", 64'($countones(gntVec) <= 1), 64'd1);
    checkOutput("rvalidOneHot", 64'($countones(rvalidVec) <= 1), 64'd1);
    if (gntVec != 3'b000) begin
      if (gntQ.size() == 0) checkOutput("gntUnexpected", 64'(gntVec), 64'd0);
      else begin
        curGnt = gntQ.pop_front();
        checkOutput("gntWho", 64'(gntVec), 64'(curGnt.who));
      end
    end
    if (mem_req) begin
      checkOutput("memAddr", 64'(mem_addr), 64'(curGnt.addr));
      checkOutput("memWe", 64'(mem_we), 64'(curGnt.we));
      checkOutput("memWdata", 64'(mem_wdata), 64'(curGnt.wdata));
    end
    if (rvalidVec != 3'b000) begin
      if (doneQ.size() == 0) checkOutput("rvalidUnexpected", 64'(rvalidVec), 64'd0);
      else begin
        doneExp_t d;
        d = doneQ.pop_front();
        checkOutput("rvalidWho", 64'(rvalidVec), 64'(d.who));
        checkOutput("rdata", 64'(rdata), 64'(d.rdata));
        checkOutput("err", 64'(err), 64'(d.err));
      end
    end else begin
      checkOutput("errWithoutRvalid", 64'(err), 64'd0);
    end
  end

  // One transaction from IDLE: grant at once, mem_ready on BUSY cycle busyCycles (or timeout).
  task automatic runTxn(input logic [2:0] who, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wdata, input int busyCycles, input logic ready,
                        input logic [31:0] rd);
    logic got;
    int   waited;
    gntQ.push_back('{who: who, addr: addr, we: we, wdata: wdata});
    doneQ.push_back('{who: who, rdata: ready ? rd : 32'h0, err: !ready});
    applyStimulus(who, 1'b1, addr, we, wdata);
    got = 1'b0;
    waited = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = (gntVec == who);
      if (!got) waited++;
    end
    checkOutput("gntSeen", 64'(got), 64'd1);
    checkOutput("gntImmediate", 64'(waited), 64'd0);
    @(posedge clk); #1;
    applyStimulus(who, 1'b0, ~addr, ~we, ~wdata);
    if (!got) return;
    for (int k = 1; k <= busyCycles; k++) begin
      if (k == busyCycles && ready) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(negedge clk);
      checkOutput("memReqBusy", 64'(mem_req), 64'd1);
      checkOutput("rvalidTiming", 64'(rvalidVec), (k == busyCycles) ? 64'(who) : 64'd0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    @(negedge clk);
    checkOutput("memReqIdle", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
  endtask

  // All three request together; each drops req after its grant, the others keep asking.
  task automatic arbRound();
    logic [31:0] rrAddr[3];
    logic [3:0]  rrWe[3];
    logic [31:0] rrWdata[3];
    int          ord[3];
    logic [2:0]  g;
    logic [2:0]  oh;
    logic        got;
    rrAddr  = '{32'h110, 32'h220, 32'h330};
    rrWe    = '{4'h0, 4'hF, 4'h1};
    rrWdata = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 2};
`else
    ord = '{2, 1, 0};
`endif
    for (int i = 0; i < 3; i++) begin
      oh = 3'b001 << ord[i];
      gntQ.push_back('{who: oh, addr: rrAddr[ord[i]], we: rrWe[ord[i]], wdata: rrWdata[ord[i]]});
      doneQ.push_back('{who: oh, rdata: 32'hA000_0000 + 32'(i), err: 1'b0});
    end
    for (int r = 0; r < 3; r++) begin
      oh = 3'b001 << r;
      applyStimulus(oh, 1'b1, rrAddr[r], rrWe[r], rrWdata[r]);
    end
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      g = 3'b000;
      for (int n = 0; n < 10 && !got; n++) begin
        @(negedge clk);
        got = (gntVec != 3'b000);
        g = gntVec;
      end
      oh = 3'b001 << ord[i];
      checkOutput("arbOrder", 64'(g), 64'(oh));
      @(posedge clk); #1;
      applyStimulus(g, 1'b0, 32'hDEAD_0000, 4'h0, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'hA000_0000 + 32'(i);
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(3'b111, 1'b0, 32'h0, 4'h0, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    curGnt = '0;

    // Requests and mem_ready during reset must be ignored.
    if_req = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetGnt", 64'(gntVec), 64'd0);
    checkOutput("resetMemReq", 64'(mem_req), 64'd0);
    checkOutput("resetRvalid", 64'(rvalidVec), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    if_req = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("postResetGnt", 64'(gntVec), 64'd0);
    checkOutput("postResetMemAddr", 64'(mem_addr), 64'd0);
    checkOutput("postResetRdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;

    arbRound();

    // mem_ready while IDLE does nothing.
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("idleReadyRvalid", 64'(rvalidVec), 64'd0);
    checkOutput("idleReadyErr", 64'(err), 64'd0);
    checkOutput("idleReadyRdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;

    runTxn(3'b001, 32'h100, 4'b0000, 32'h0, 3, 1'b1, 32'h0050_0093);
    runTxn(3'b010, 32'h2000, 4'b0011, 32'hAABB_CCDD, 4, 1'b1, 32'h1234_5678);
    runTxn(3'b100, 32'h4000, 4'b0000, 32'h0, MAX_WAIT, 1'b0, 32'h0);
    runTxn(3'b010, 32'h5000, 4'b1111, 32'h0BAD_F00D, MAX_WAIT, 1'b1, 32'hCAFE_F00D);

    // Reset on the second BUSY cycle abandons the transaction.
    gntQ.push_back('{who: 3'b001, addr: 32'h300, we: 4'h0, wdata: 32'h0});
    applyStimulus(3'b001, 1'b1, 32'h300, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("rstTxnGnt", 64'(gntVec), 64'd1);
    @(posedge clk); #1;
    applyStimulus(3'b001, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("rstTxnBusy", 64'(mem_req), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    checkOutput("rstTxnNoRvalid", 64'(rvalidVec), 64'd0);
    checkOutput("rstTxnNoErr", 64'(err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("rstTxnMemReq", 64'(mem_req), 64'd0);
    checkOutput("rstTxnRvalidAfter", 64'(rvalidVec), 64'd0);
    @(posedge clk); #1;

    runTxn(3'b001, 32'h600, 4'b0000, 32'h0, 2, 1'b1, 32'h1357_9BDF);

    checkOutput("gntQEmpty", 64'(gntQ.size()), 64'd0);
    checkOutput("doneQEmpty", 64'(doneQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, 16, the number of BUSY cycles without mem_ready before timeout; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; reset=0 at a clk edge resets the block.
REQ-004 SHALL have ports if_req, ls_req, dbg_req  input  1 each  transaction requests from the fetch, load/store and debug requesters.
REQ-005 SHALL have ports if_addr, ls_addr, dbg_addr  input  32 each  byte addresses.
REQ-006 SHALL have ports if_we, ls_we, dbg_we  input  4 each  byte write strobes; 4'b0000 means read.
REQ-007 SHALL have ports if_wdata, ls_wdata, dbg_wdata  input  32 each  write data.
REQ-008 SHALL have ports if_gnt, ls_gnt, dbg_gnt  output  1 each  one-cycle grant pulses.
REQ-009 SHALL have ports if_rvalid, ls_rvalid, dbg_rvalid  output  1 each  one-cycle completion pulses.
REQ-010 SHALL have port rdata  output  32  completion data, shared by all requesters.
REQ-011 SHALL have port err  output  1  timeout flag, pulsed together with rvalid.
REQ-012 SHALL have ports mem_req  output  1, mem_addr  output  32, mem_we  output  4, mem_wdata  output  32  the unified memory port.
REQ-013 SHALL have ports mem_ready  input  1, mem_rdata  input  32  memory completion and read data.

Function
REQ-014 SHALL implement the states IDLE and BUSY, encoded in a 1-bit register.
REQ-015 SHALL, in IDLE with any req high, select one winner, latch its addr, we and wdata, pulse its gnt for that cycle, and enter BUSY on the next edge.
REQ-016 SHALL, in IDLE with no req high, hold all outputs at 0 and stay in IDLE.
REQ-017 SHALL, without the configuration macro, use fixed priority dbg > ls > if.
REQ-018 SHALL sample req, addr, we and wdata only in IDLE; input changes during BUSY have no effect.
REQ-019 SHALL, in BUSY, drive mem_req=1 with the latched mem_addr, mem_we and mem_wdata, held stable until completion.
REQ-020 SHALL, on a BUSY cycle with mem_ready=1, pulse the owner's rvalid in that same cycle, drive rdata=mem_rdata (reads and writes alike), and return to IDLE.
REQ-021 SHALL drive mem_req=0 in IDLE, so each transaction is followed by at least one arbitration cycle; minimum grant-to-grant spacing is 2 cycles.
REQ-022 SHALL count BUSY cycles in an 8-bit counter cleared on entry to BUSY.
REQ-023 SHALL, when the counter reaches MAX_WAIT with mem_ready=0, pulse the owner's rvalid and err with rdata=32'h0, and return to IDLE.
REQ-024 SHALL treat mem_ready=1 on the same cycle as the timeout as a normal completion with err=0.
REQ-025 SHALL ignore mem_ready while in IDLE.
REQ-026 SHALL keep gnt and rvalid one-hot or all zero in every cycle.
REQ-027 SHALL require each requester to drop req in the cycle after its gnt; a req still high at the next IDLE is a new request.

Reset
REQ-028 SHALL, on reset=0 at a clk edge, enter IDLE, clear the counter and the latches, and reset the round-robin pointer (when built) to if.
REQ-029 SHALL drive all outputs to 0 during reset and in the cycle after it.
REQ-030 SHALL, on reset during BUSY, abandon the transaction with no rvalid and no err, and drop mem_req from the next cycle.

Configuration
REQ-031 SHALL honour the macro MEM_ARB_ROUND_ROBIN_EN.
REQ-032 SHALL, with MEM_ARB_ROUND_ROBIN_EN defined, arbitrate round-robin over the order if -> ls -> dbg -> if, starting the search after the last granted requester.
REQ-033 SHALL, with MEM_ARB_ROUND_ROBIN_EN undefined, use the fixed priority of REQ-017 and contain no pointer register.

Verification
REQ-034 SHALL cover: if_req=1 with if_addr=32'h100, if_we=0; mem_ready high 3 cycles later with mem_rdata=32'h00500093 -> if_gnt at cycle 0, mem_req cycles 1-3, if_rvalid and rdata=32'h00500093 at cycle 3.
REQ-035 SHALL cover: ls_req with ls_we=4'b0011, ls_wdata=32'hAABBCCDD, ls_addr=32'h2000 -> mem_we=4'b0011, mem_wdata=32'hAABBCCDD, mem_addr=32'h2000 held until mem_ready, then ls_rvalid.
REQ-036 SHALL cover: all three req high in the same IDLE cycle, fixed-priority build -> grant order dbg, ls, if when re-requested; round-robin build from reset -> if, ls, dbg.
REQ-037 SHALL cover: mem_ready held 0 with MAX_WAIT=16 -> owner rvalid and err pulse on the 16th BUSY cycle, rdata=0, then IDLE.
REQ-038 SHALL cover: reset=0 on the 2nd BUSY cycle -> no rvalid, mem_req=0 on the next cycle, and a new if_req is granted normally after reset=1.
REQ-039 SHALL cover: mem_ready=1 on the same cycle as the timeout -> normal completion with err=0 and rdata=mem_rdata.
